// File: rtl/sub_pipe_defs.sv
// Shared constants for the two-stage pipelined subtractor sub_pipe.
package sub_pipe_defs;

    localparam int W  = 4;
    localparam int HW = W / 2;

    localparam logic [W-1:0] DIF_RST = '0;

endpackage

// File: rtl/sub_etapa.sv
// Half-width registered subtract stage: {borrow_out, dif} <= a - b - borrow_in when enabled.
module sub_etapa
    import sub_pipe_defs::*;
#(
    parameter int HW = sub_pipe_defs::HW
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          enable,
    input  logic [HW-1:0] a,
    input  logic [HW-1:0] b,
    input  logic          borrow_in,
    output logic [HW-1:0] dif,
    output logic          borrow_out
);

    // One extra bit on the left catches the borrow out of the half-width subtract.
    logic [HW:0] full;

    always_comb begin
        full = {1'b0, a} - {1'b0, b} - {{HW{1'b0}}, borrow_in};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            dif        <= '0;
            borrow_out <= 1'b0;
        end else if (enable) begin
            dif        <= full[HW-1:0];
            borrow_out <= full[HW];
        end
    end

endmodule

// File: rtl/sub_pipe.sv
// Two-stage pipelined W-bit subtractor with valid tag; define SUB_PIPE_CHECK_EN to add the
// adder-direction self-check output err_dd.
module sub_pipe
    import sub_pipe_defs::*;
#(
    parameter int W = sub_pipe_defs::W
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic [W-1:0] dataA,
    input  logic [W-1:0] dataB,
    input  logic         valid_in,
    output logic [W-1:0] dif_dd,
    output logic         borrow_dd,
    output logic         valid_dd
`ifdef SUB_PIPE_CHECK_EN
    ,
    output logic         err_dd
`endif
);

    localparam int H = W / 2;
    localparam logic [W-1:0] DIF_RST_W = W'(DIF_RST);

    logic         valid_d;
    logic [H-1:0] dif_lo_d;
    logic         borrow_lo_d;
    logic [H-1:0] a_hi_d;
    logic [H-1:0] b_hi_d;
    logic [H-1:0] dif_lo_dd;
    logic [H-1:0] dif_hi_dd;

    // Stage 1: low half, no incoming borrow.
    sub_etapa #(.HW(H)) u_stage_lo (
        .clk        (clk),
        .reset_L    (reset_L),
        .enable     (valid_in),
        .a          (dataA[H-1:0]),
        .b          (dataB[H-1:0]),
        .borrow_in  (1'b0),
        .dif        (dif_lo_d),
        .borrow_out (borrow_lo_d)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_d <= 1'b0;
            a_hi_d  <= '0;
            b_hi_d  <= '0;
        end else begin
            valid_d <= valid_in;
            if (valid_in) begin
                a_hi_d <= dataA[W-1:H];
                b_hi_d <= dataB[W-1:H];
            end
        end
    end

    // Stage 2: high half consumes the registered low-half borrow, so no input-to-output path exists.
    sub_etapa #(.HW(H)) u_stage_hi (
        .clk        (clk),
        .reset_L    (reset_L),
        .enable     (valid_d),
        .a          (a_hi_d),
        .b          (b_hi_d),
        .borrow_in  (borrow_lo_d),
        .dif        (dif_hi_dd),
        .borrow_out (borrow_dd)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_dd  <= 1'b0;
            dif_lo_dd <= DIF_RST_W[H-1:0];
        end else begin
            valid_dd <= valid_d;
            if (valid_d) begin
                dif_lo_dd <= dif_lo_d;
            end
        end
    end

    assign dif_dd = {dif_hi_dd, dif_lo_dd};

`ifdef SUB_PIPE_CHECK_EN
    logic [W-1:0] a_d;
    logic [W-1:0] b_d;
    logic [H-1:0] chk_hi;
    logic [W-1:0] chk_sum;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            a_d <= '0;
            b_d <= '0;
        end else if (valid_in) begin
            a_d <= dataA;
            b_d <= dataB;
        end
    end

    // NOTE: every always_comb target gets a value on every path, so no latch is inferred.
    always_comb begin
        chk_hi  = a_hi_d - b_hi_d - H'(borrow_lo_d);
        chk_sum = {chk_hi, dif_lo_d} + b_d;
    end

    // Re-adding the subtrahend must reproduce the minuend.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_dd <= 1'b0;
        end else begin
            err_dd <= valid_d & (chk_sum != a_d);
        end
    end
`endif

endmodule

// File: tb/tb_sub_pipe.sv
// Scoreboard bench for sub_pipe: expected results are queued at drive time and popped as valid_dd rises.
module tb_sub_pipe;

    typedef struct packed {
        logic [3:0] dif;
        logic       borrow;
    } res_t;

    logic       clk;
    logic       reset_L;
    logic [3:0] dataA;
    logic [3:0] dataB;
    logic       valid_in;
    logic [3:0] dif_dd;
    logic       borrow_dd;
    logic       valid_dd;
    logic       err_dd;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t last;
    logic m_vd;
    logic m_vdd;

    sub_pipe #(.W(4)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .dataA     (dataA),
        .dataB     (dataB),
        .valid_in  (valid_in),
        .dif_dd    (dif_dd),
        .borrow_dd (borrow_dd),
        .valid_dd  (valid_dd)
`ifdef SUB_PIPE_CHECK_EN
        ,
        .err_dd    (err_dd)
`endif
    );

`ifndef SUB_PIPE_CHECK_EN
    assign err_dd = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one cycle of stimulus and advances the reference valid pipeline past the edge.
    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
        res_t r;
        @(negedge clk);
        valid_in = v;
        dataA    = a;
        dataB    = b;
        if (v) begin
            r.dif    = a - b;
            r.borrow = (a < b);
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        m_vdd = m_vd;
        m_vd  = v;
    endtask

    task automatic test_reset();
        reset_L  = 1'b0;
        valid_in = 1'b0;
        dataA    = 4'h0;
        dataB    = 4'h0;
        m_vd     = 1'b0;
        m_vdd    = 1'b0;
        last     = '0;
        #1;
        checks++;
        if ({dif_dd, borrow_dd, valid_dd, err_dd} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state: got dif=%h borrow=%b valid=%b err=%b want all 0",
                     dif_dd, borrow_dd, valid_dd, err_dd);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dif_dd, borrow_dd, valid_dd, err_dd} !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold: got dif=%h borrow=%b valid=%b err=%b want all 0",
                     dif_dd, borrow_dd, valid_dd, err_dd);
        end
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    // Back-to-back vectors covering basic, negative, cross-half borrow and both wrap boundaries.
    task automatic test_back_to_back();
        logic [8:0] vec [0:6];
        vec = '{ {1'b1, 4'd9,  4'd3},  {1'b1, 4'd3,  4'd9},  {1'b1, 4'd8, 4'd1},
                 {1'b1, 4'd0,  4'd15}, {1'b1, 4'd15, 4'd15}, {1'b0, 4'd0, 4'd0},
                 {1'b0, 4'd0,  4'd0} };
        for (int i = 0; i < 7; i++) begin
            drive(vec[i][8], vec[i][7:4], vec[i][3:0]);
            checks++;
            if (valid_dd !== m_vdd) begin
                errors++;
                $display("FAIL b2b[%0d] valid_dd: got %b want %b", i, valid_dd, m_vdd);
            end
            if (m_vdd && exp_q.size() > 0) last = exp_q.pop_front();
            checks++;
            if (dif_dd !== last.dif) begin
                errors++;
                $display("FAIL b2b[%0d] dif_dd: got %h want %h", i, dif_dd, last.dif);
            end
            checks++;
            if (borrow_dd !== last.borrow) begin
                errors++;
                $display("FAIL b2b[%0d] borrow_dd: got %b want %b", i, borrow_dd, last.borrow);
            end
`ifdef SUB_PIPE_CHECK_EN
            checks++;
            if (err_dd !== 1'b0) begin
                errors++;
                $display("FAIL b2b[%0d] err_dd: got %b want 0", i, err_dd);
            end
`endif
        end
    endtask

    // Stream with one bubble; outputs must hold the last result while valid_dd is low.
    task automatic test_bubble();
        logic [8:0] vec [0:5];
        vec = '{ {1'b1, 4'd5, 4'd2}, {1'b1, 4'd7, 4'd7}, {1'b0, 4'd6, 4'd1},
                 {1'b1, 4'd2, 4'd4}, {1'b0, 4'd0, 4'd0}, {1'b0, 4'd0, 4'd0} };
        for (int i = 0; i < 6; i++) begin
            drive(vec[i][8], vec[i][7:4], vec[i][3:0]);
            checks++;
            if (valid_dd !== m_vdd) begin
                errors++;
                $display("FAIL bubble[%0d] valid_dd: got %b want %b", i, valid_dd, m_vdd);
            end
            if (m_vdd && exp_q.size() > 0) last = exp_q.pop_front();
            checks++;
            if (dif_dd !== last.dif) begin
                errors++;
                $display("FAIL bubble[%0d] dif_dd: got %h want %h", i, dif_dd, last.dif);
            end
            checks++;
            if (borrow_dd !== last.borrow) begin
                errors++;
                $display("FAIL bubble[%0d] borrow_dd: got %b want %b", i, borrow_dd, last.borrow);
            end
`ifdef SUB_PIPE_CHECK_EN
            checks++;
            if (err_dd !== 1'b0) begin
                errors++;
                $display("FAIL bubble[%0d] err_dd: got %b want 0", i, err_dd);
            end
`endif
        end
    endtask

    // Asynchronous reset with results in flight, then recovery on a fresh operand.
    task automatic test_reset_midflight();
        logic [8:0] vec [0:5];
        drive(1'b1, 4'd9, 4'd3);
        drive(1'b1, 4'd3, 4'd9);
        #3;
        reset_L  = 1'b0;
        valid_in = 1'b0;
        #1;
        checks++;
        if ({dif_dd, borrow_dd, valid_dd, err_dd} !== 7'b0) begin
            errors++;
            $display("FAIL midflight_reset: got dif=%h borrow=%b valid=%b err=%b want all 0",
                     dif_dd, borrow_dd, valid_dd, err_dd);
        end
        exp_q.delete();
        m_vd  = 1'b0;
        m_vdd = 1'b0;
        last  = '0;
        @(negedge clk);
        reset_L = 1'b1;
        vec = '{ {1'b0, 4'd9, 4'd3}, {1'b0, 4'd9, 4'd3}, {1'b0, 4'd9, 4'd3},
                 {1'b1, 4'd8, 4'd1}, {1'b0, 4'd0, 4'd0}, {1'b0, 4'd0, 4'd0} };
        for (int i = 0; i < 6; i++) begin
            drive(vec[i][8], vec[i][7:4], vec[i][3:0]);
            checks++;
            if (valid_dd !== m_vdd) begin
                errors++;
                $display("FAIL recover[%0d] valid_dd: got %b want %b", i, valid_dd, m_vdd);
            end
            if (m_vdd && exp_q.size() > 0) last = exp_q.pop_front();
            checks++;
            if (dif_dd !== last.dif) begin
                errors++;
                $display("FAIL recover[%0d] dif_dd: got %h want %h", i, dif_dd, last.dif);
            end
            checks++;
            if (borrow_dd !== last.borrow) begin
                errors++;
                $display("FAIL recover[%0d] borrow_dd: got %b want %b", i, borrow_dd, last.borrow);
            end
`ifdef SUB_PIPE_CHECK_EN
            checks++;
            if (err_dd !== 1'b0) begin
                errors++;
                $display("FAIL recover[%0d] err_dd: got %b want 0", i, err_dd);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bubble();
        test_reset_midflight();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending results want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
